// File: rtl/prog_timer.sv
// Programmable up-counter timer with prescaler, one-shot and periodic modes.
// Settings are latched on start; expire is a registered pulse on reaching the limit.
module prog_timer #(
    parameter int WIDTH = 8,
    parameter int PS_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [PS_W-1:0]  prescale,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expire
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = 1;
    localparam logic [PS_W-1:0]  PS_ONE  = 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PS_W-1:0]  psc_q, psc_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             mode_q, mode_d;
    logic             expire_q, expire_d;
    logic [WIDTH-1:0] step_count;

    // A step from the limit (periodic only) reloads 0, so count never passes lim_q.
    assign step_count = (count_q == lim_q) ? '0 : count_q + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            psc_q    <= '0;
            lim_q    <= '0;
            ps_q     <= '0;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            psc_q    <= psc_d;
            lim_q    <= lim_d;
            ps_q     <= ps_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        psc_d    = psc_q;
        lim_d    = lim_q;
        ps_d     = ps_q;
        mode_d   = mode_q;
        expire_d = 1'b0;

        if (start) begin
            count_d = '0;
            psc_d   = '0;
            lim_d   = limit;
            ps_d    = prescale;
            mode_d  = mode;
            if (limit != '0) begin
                state_d = S_RUN;
            end else begin
                // A zero limit is reached immediately on arming.
                expire_d = 1'b1;
                state_d  = mode ? S_RUN : S_DONE;
            end
        end else if (stop) begin
            state_d = S_IDLE;
        end else if (state_q == S_RUN && tick) begin
            if (psc_q == ps_q) begin
                psc_d    = '0;
                count_d  = step_count;
                expire_d = (step_count == lim_q);
                if (!mode_q && step_count == lim_q) begin
                    state_d = S_DONE;
                end
            end else begin
                psc_d = psc_q + PS_ONE;
            end
        end
    end

    assign count  = count_q;
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign expire = expire_q;

endmodule

// File: tb/tb_prog_timer.sv
// Table-driven bench for prog_timer: per-cycle vectors go through a scoreboard
// queue, followed by hand-written asynchronous reset sequences.
module tb_prog_timer;

    logic       clk = 1'b0;
    logic       rst, start, stop, mode, tick;
    logic [7:0] limit, count;
    logic [3:0] prescale;
    logic       busy, done, expire;

    always #5 clk = ~clk;

    prog_timer #(.WIDTH(8), .PS_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .limit    (limit),
        .prescale (prescale),
        .tick     (tick),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .expire   (expire)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       mode;
        logic [7:0] limit;
        logic [3:0] prescale;
        logic       tick;
        logic [7:0] e_count;
        logic       e_busy;
        logic       e_done;
        logic       e_expire;
        int         phase;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] sb[$];

    task automatic add(input logic st, input logic sp, input logic md,
                       input logic [7:0] lim, input logic [3:0] ps, input logic tk,
                       input logic [7:0] ec, input logic eb, input logic ed,
                       input logic ee, input int ph);
        vec_t v;
        v.start = st; v.stop = sp; v.mode = md; v.limit = lim; v.prescale = ps;
        v.tick = tk; v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_expire = ee;
        v.phase = ph;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [7:0] ec,
                              input logic eb, input logic ed, input logic ee);
        check(name, {21'd0, count, busy, done, expire}, {21'd0, ec, eb, ed, ee});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        limit = 8'd0; prescale = 4'd0; tick = 1'b0;

        // Phase 0: idle after reset, ticks ignored until start.
        add(0, 0, 0, 8'd7, 4'd0, 1, 8'd0, 0, 0, 0, 0);
        add(0, 0, 1, 8'd7, 4'd0, 1, 8'd0, 0, 0, 0, 0);

        // Phase 1: one-shot limit=5, prescale=0.
        add(1, 0, 0, 8'd5, 4'd0, 1, 8'd0, 1, 0, 0, 1);
        for (int i = 1; i <= 5; i++)
            add(0, 0, 0, 8'd5, 4'd0, 1, 8'(i), (i < 5), (i == 5), (i == 5), 1);
        for (int i = 0; i < 10; i++)
            add(0, 0, 1, 8'd2, 4'd0, 1, 8'd5, 0, 1, 0, 1);

        // Phase 2: periodic limit=3, prescale=2; step every 3 cycles, expire every 12.
        add(1, 0, 1, 8'd3, 4'd2, 1, 8'd0, 1, 0, 0, 2);
        for (int i = 1; i <= 25; i++)
            add(0, 0, 1, 8'd3, 4'd2, 1, 8'((i / 3) % 4), 1, 0,
                ((i % 3 == 0) && ((i / 3) % 4 == 3)), 2);

        // Phase 3: one-shot limit=0 completes on arming.
        add(1, 0, 0, 8'd0, 4'd0, 1, 8'd0, 0, 1, 1, 3);
        add(0, 0, 0, 8'd0, 4'd0, 1, 8'd0, 0, 1, 0, 3);

        // Phase 4: periodic limit=0, prescale=0 pulses expire every cycle.
        add(1, 0, 1, 8'd0, 4'd0, 1, 8'd0, 1, 0, 1, 4);
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, 8'd9, 4'd3, 1, 8'd0, 1, 0, 1, 4);

        // Phase 5: start+stop restarts; stop alone aborts and holds count.
        add(1, 0, 0, 8'd5, 4'd0, 1, 8'd0, 1, 0, 0, 5);
        add(0, 0, 0, 8'd5, 4'd0, 1, 8'd1, 1, 0, 0, 5);
        add(0, 0, 0, 8'd5, 4'd0, 1, 8'd2, 1, 0, 0, 5);
        add(1, 1, 0, 8'd5, 4'd0, 1, 8'd0, 1, 0, 0, 5);
        add(0, 0, 0, 8'd5, 4'd0, 1, 8'd1, 1, 0, 0, 5);
        add(0, 0, 0, 8'd5, 4'd0, 1, 8'd2, 1, 0, 0, 5);
        add(0, 1, 0, 8'd5, 4'd0, 1, 8'd2, 0, 0, 0, 5);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 8'd5, 4'd0, 1, 8'd2, 0, 0, 0, 5);

        // Phase 6: limit=4, prescale=1, toggled tick, limit input changed mid-run.
        add(1, 0, 0, 8'd4, 4'd1, 1, 8'd0, 1, 0, 0, 6);
        for (int i = 1; i <= 18; i++) begin
            int c;
            c = (i + 1) / 4;
            if (c > 4) c = 4;
            add(0, 0, 1, (i >= 2) ? 8'd1 : 8'd4, (i >= 2) ? 4'd0 : 4'd1, (i % 2 == 1),
                8'(c), (c < 4), (c == 4), (i == 15), 6);
        end

        // Reset state, checked after the first clock edge with rst held.
        @(posedge clk); #2;
        check_outs("reset_state", 8'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [10:0] exp_v;
            @(negedge clk);
            start = vecs[i].start; stop = vecs[i].stop; mode = vecs[i].mode;
            limit = vecs[i].limit; prescale = vecs[i].prescale; tick = vecs[i].tick;
            sb.push_back({vecs[i].e_count, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_expire});
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            check_outs($sformatf("vec%0d_ph%0d", i, vecs[i].phase),
                       exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
        end

        // Async reset mid-RUN at count=3 clears outputs before the next edge.
        @(negedge clk);
        start = 1'b1; stop = 1'b0; mode = 1'b1; limit = 8'd8; prescale = 4'd0; tick = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_outs("pre_rst_count3", 8'd3, 1, 0, 0);
        #2 rst = 1'b1;
        #1 check_outs("async_rst_run", 8'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outs($sformatf("post_rst_idle%0d", i), 8'd0, 0, 0, 0);
        end

        // Async reset while expire is pulsing must drop it immediately.
        start = 1'b1; mode = 1'b1; limit = 8'd0; prescale = 4'd0; tick = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_outs("pre_rst_expire", 8'd0, 1, 0, 1);
        #2 rst = 1'b1;
        #1 check_outs("async_rst_expire", 8'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outs("post_rst_expire_idle", 8'd0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
